tlb_cmd_ctrl: RTL and testbench
===============================

Name: tlb_cmd_ctrl

Overview:
Sequences committed TLB maintenance commands (TLBRD, TLBWR, TLBFILL) leaving the WB stage onto the shared TLB read/write ports and the CSR TLB-register update path.
- Selects the fill index.
- Holds the pipeline busy while a command is in flight.
- Issues a refetch redirect to PC+4 when the command completes.
- Sits between the WB stage, the TLB and the CSR file.

Parameters:
- TLBNUM, 16, number of TLB entries; must equal 2**IDX_W.
- IDX_W, 4, TLB index width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  WB offers a committed TLB command.
- cmd_ready  out  1  controller accepts a command; equals (state==IDLE).
- cmd_op  in  3  one-hot {rd, fill, wr}.
- cmd_pc  in  32  PC of the command instruction.
- csr_tlbidx_index  in  IDX_W  TLBIDX.INDEX from the CSR file.
- tlb_busy  out  1  command in flight; WB/EX stall TLB-dependent instructions.
- tlb_we  out  1  TLB write strobe, one-cycle pulse.
- tlb_w_index  out  IDX_W  write index.
- tlb_r_index  out  IDX_W  read index.
- tlb_r_e  in  1  valid bit of the entry read; sampled one cycle after the index is driven.
- csr_tlbrd_we  out  1  one-cycle pulse: the CSR file loads TLBEHI/TLBELO0/1/ASID/TLBIDX from the TLB read data.
- csr_tlbrd_valid  out  1  qualifies csr_tlbrd_we; equals the sampled tlb_r_e.
- refetch_valid  out  1  redirect request.
- refetch_ready  in  1  fetch accepts the redirect.
- refetch_pc  out  32  cmd_pc + 4.

Behaviour:
- Reset (async, resetn=0): state=IDLE; fill index = 0 (LFSR seed 1 with the feature). All outputs 0 except cmd_ready=1. Reset mid-command abandons it: no tlb_we, no CSR pulse, no refetch.
- States: IDLE, WRITE, RD_REQ, RD_RESP, REFETCH.
- IDLE:
  - Accept when cmd_valid && cmd_ready.
  - Capture cmd_pc and csr_tlbidx_index. For fill, capture the current fill index.
  - wr or fill -> WRITE; rd -> RD_REQ.
  - cmd_op not one-hot (including 0): the command is consumed and dropped; state stays IDLE.
- WRITE (1 cycle):
  - tlb_we=1.
  - tlb_w_index = captured TLBIDX index (wr) or captured fill index (fill).
  - Next state REFETCH.
- RD_REQ (1 cycle): tlb_r_index = captured index; next state RD_RESP.
- RD_RESP (1 cycle):
  - tlb_r_index is held.
  - csr_tlbrd_we=1 and csr_tlbrd_valid=tlb_r_e.
  - Next state REFETCH.
- REFETCH:
  - refetch_valid=1 and refetch_pc = captured pc + 4 (mod 2^32; 0xFFFFFFFC wraps to 0).
  - Both are held stable until refetch_ready. On the handshake cycle the state moves to IDLE, and the next command can be accepted on the following cycle.
- tlb_busy = (state != IDLE). cmd_ready and refetch_valid are never both 1.
- Latency from accept edge:
  - WR/FILL: tlb_we on cycle 1, refetch_valid from cycle 2.
  - RD: csr_tlbrd_we on cycle 2, refetch_valid from cycle 3.
- Fill index: a free-running counter incrementing every clock, modulo TLBNUM; wraps TLBNUM-1 -> 0. The value is sampled at accept, not at WRITE.
- tlb_w_index and tlb_r_index are 0 when not in their active states.

Optional Feature:
- Macro TLB_FILL_LFSR_EN.
- Defined: the fill index comes from an IDX_W-bit Fibonacci LFSR stepped every clock. Seed is 1 at reset. Taps come from the package table (IDX_W=4: x^4+x^3+1). The value 0 never occurs, so entry 0 is never chosen by a fill.
- Undefined: the modulo counter described in Behaviour.

Decomposition:
- Package tlb_cmd_pkg: state encoding constants; CMD_RD/CMD_FILL/CMD_WR bit positions (2/1/0); the LFSR tap table per IDX_W.
- One sub-module, tlb_fill_sel: owns the counter/LFSR and outputs fill_idx.

Test Plan:
- TLBWR, index=5, pc=0x1C000100, refetch_ready=1: tlb_we on cycle 1 with index 5; refetch_valid cycle 2 with pc=0x1C000104; cmd_ready=1 on cycle 3.
- TLBRD, index=3, tlb_r_e=1: tlb_r_index=3 on cycles 1-2; csr_tlbrd_we=1 and csr_tlbrd_valid=1 on cycle 2; refetch on cycle 3.
- TLBFILL twice, 16 cycles apart: counter build gives identical indices; with TLB_FILL_LFSR_EN, indices differ and neither is 0.
- refetch_ready held 0 for 4 cycles: refetch_valid and refetch_pc stay stable; cmd_valid is not accepted; tlb_busy=1 throughout.
- cmd_op=3'b011: consumed in one cycle; no tlb_we, no csr_tlbrd_we, no refetch_valid.
- resetn pulsed low during RD_RESP: outputs clear immediately; no refetch after release; cmd_ready=1.

Source files
------------

// File: rtl/tlb_cmd_pkg.sv
// Shared state encoding, command bit positions and LFSR tap table for the TLB command sequencer.
package tlb_cmd_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StWrite   = 3'd1,
        StRdReq   = 3'd2,
        StRdResp  = 3'd3,
        StRefetch = 3'd4
    } tlb_cmd_state_e;

    localparam int unsigned CMD_RD   = 2;
    localparam int unsigned CMD_FILL = 1;
    localparam int unsigned CMD_WR   = 0;

    // Maximal-length Fibonacci tap masks; bit i set means register bit i feeds the XOR.
    function automatic logic [7:0] lfsr_taps(input int unsigned width);
        case (width)
            2:       return 8'h03;
            3:       return 8'h06;
            4:       return 8'h0C;
            5:       return 8'h14;
            6:       return 8'h30;
            7:       return 8'h60;
            default: return 8'hB8;
        endcase
    endfunction

endpackage

// File: rtl/tlb_fill_sel.sv
// Fill-index source: free-running modulo counter, or a nonzero LFSR when TLB_FILL_LFSR_EN is defined.
module tlb_fill_sel #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [IDX_W-1:0] fill_idx
);
    import tlb_cmd_pkg::*;

`ifdef TLB_FILL_LFSR_EN
    localparam logic [7:0]       TapTable = lfsr_taps(IDX_W);
    localparam logic [IDX_W-1:0] Taps     = TapTable[IDX_W-1:0];

    logic [IDX_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[IDX_W-2:0], ^(lfsr_q & Taps)};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q <= IDX_W'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign fill_idx = lfsr_q;
`else
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == IDX_W'(TLBNUM - 1)) ? '0 : cnt_q + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fill_idx = cnt_q;
`endif

endmodule

// File: rtl/tlb_cmd_ctrl.sv
// Sequences committed TLBRD/TLBWR/TLBFILL onto the TLB ports and CSR update path, then refetches PC+4.
// Define TLB_FILL_LFSR_EN to draw fill indices from an LFSR instead of a modulo counter.
module tlb_cmd_ctrl #(
    parameter int unsigned TLBNUM = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [31:0]      cmd_pc,
    input  logic [IDX_W-1:0] csr_tlbidx_index,
    output logic             tlb_busy,
    output logic             tlb_we,
    output logic [IDX_W-1:0] tlb_w_index,
    output logic [IDX_W-1:0] tlb_r_index,
    input  logic             tlb_r_e,
    output logic             csr_tlbrd_we,
    output logic             csr_tlbrd_valid,
    output logic             refetch_valid,
    input  logic             refetch_ready,
    output logic [31:0]      refetch_pc
);
    import tlb_cmd_pkg::*;

    tlb_cmd_state_e   state_q;
    logic [31:0]      pc_q;
    logic             tlb_we_q;
    logic [IDX_W-1:0] w_index_q;
    logic [IDX_W-1:0] r_index_q;
    logic             rd_we_q;
    logic             refetch_valid_q;
    logic [31:0]      refetch_pc_q;
    logic [IDX_W-1:0] fill_idx;
    logic             op_onehot;

    tlb_fill_sel #(
        .TLBNUM (TLBNUM),
        .IDX_W  (IDX_W)
    ) u_fill_sel (
        .clk      (clk),
        .resetn   (resetn),
        .fill_idx (fill_idx)
    );

    assign op_onehot = $onehot(cmd_op);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= StIdle;
            pc_q            <= '0;
            tlb_we_q        <= 1'b0;
            w_index_q       <= '0;
            r_index_q       <= '0;
            rd_we_q         <= 1'b0;
            refetch_valid_q <= 1'b0;
            refetch_pc_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Malformed ops are consumed here without leaving IDLE.
                    if (cmd_valid && cmd_ready && op_onehot) begin
                        pc_q <= cmd_pc;
                        if (cmd_op[CMD_RD]) begin
                            r_index_q <= csr_tlbidx_index;
                            state_q   <= StRdReq;
                        end else begin
                            tlb_we_q  <= 1'b1;
                            w_index_q <= cmd_op[CMD_FILL] ? fill_idx : csr_tlbidx_index;
                            state_q   <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    tlb_we_q        <= 1'b0;
                    w_index_q       <= '0;
                    refetch_valid_q <= 1'b1;
                    refetch_pc_q    <= pc_q + 32'd4;
                    state_q         <= StRefetch;
                end
                StRdReq: begin
                    rd_we_q <= 1'b1;
                    state_q <= StRdResp;
                end
                StRdResp: begin
                    rd_we_q         <= 1'b0;
                    r_index_q       <= '0;
                    refetch_valid_q <= 1'b1;
                    refetch_pc_q    <= pc_q + 32'd4;
                    state_q         <= StRefetch;
                end
                StRefetch: begin
                    if (refetch_ready) begin
                        refetch_valid_q <= 1'b0;
                        refetch_pc_q    <= '0;
                        state_q         <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready       = (state_q == StIdle);
    assign tlb_busy        = (state_q != StIdle);
    assign tlb_we          = tlb_we_q;
    assign tlb_w_index     = w_index_q;
    assign tlb_r_index     = r_index_q;
    assign csr_tlbrd_we    = rd_we_q;
    // The read entry is valid in RD_RESP, one cycle after its index was presented.
    assign csr_tlbrd_valid = rd_we_q & tlb_r_e;
    assign refetch_valid   = refetch_valid_q;
    assign refetch_pc      = refetch_pc_q;

endmodule

// File: tb/tb_tlb_cmd_ctrl.sv
// Directed bench for tlb_cmd_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_tlb_cmd_ctrl;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_pc;
    logic [3:0]  csr_tlbidx_index;
    logic        tlb_busy;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic [3:0]  tlb_r_index;
    logic        tlb_r_e;
    logic        csr_tlbrd_we;
    logic        csr_tlbrd_valid;
    logic        refetch_valid;
    logic        refetch_ready;
    logic [31:0] refetch_pc;

    int vectors;
    int miscompares;

    logic [3:0] fill_model;
    logic [3:0] fill_at_edge;

    tlb_cmd_ctrl #(
        .TLBNUM (16),
        .IDX_W  (4)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_op           (cmd_op),
        .cmd_pc           (cmd_pc),
        .csr_tlbidx_index (csr_tlbidx_index),
        .tlb_busy         (tlb_busy),
        .tlb_we           (tlb_we),
        .tlb_w_index      (tlb_w_index),
        .tlb_r_index      (tlb_r_index),
        .tlb_r_e          (tlb_r_e),
        .csr_tlbrd_we     (csr_tlbrd_we),
        .csr_tlbrd_valid  (csr_tlbrd_valid),
        .refetch_valid    (refetch_valid),
        .refetch_ready    (refetch_ready),
        .refetch_pc       (refetch_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference fill-index source; fill_at_edge is the value present at the latest rising edge.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
`ifdef TLB_FILL_LFSR_EN
            fill_model <= 4'd1;
`else
            fill_model <= 4'd0;
`endif
            fill_at_edge <= 4'd0;
        end else begin
            fill_at_edge <= fill_model;
`ifdef TLB_FILL_LFSR_EN
            fill_model <= {fill_model[2:0], fill_model[3] ^ fill_model[2]};
`else
            fill_model <= fill_model + 4'd1;
`endif
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] idx, input logic [31:0] pc);
        cmd_valid        = 1'b1;
        cmd_op           = op;
        csr_tlbidx_index = idx;
        cmd_pc           = pc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++;
            $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        vectors++; if (tlb_busy !== 1'b0) begin miscompares++;
            $display("FAIL rst_busy: got %b want 0", tlb_busy); end
        vectors++; if ({tlb_we, csr_tlbrd_we, csr_tlbrd_valid, refetch_valid} !== 4'b0) begin
            miscompares++; $display("FAIL rst_strobes: got %b want 0000",
                {tlb_we, csr_tlbrd_we, csr_tlbrd_valid, refetch_valid}); end
        vectors++; if ({tlb_w_index, tlb_r_index, refetch_pc} !== 40'h0) begin miscompares++;
            $display("FAIL rst_data: got %h want 0", {tlb_w_index, tlb_r_index, refetch_pc}); end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write(input logic [3:0] idx, input logic [31:0] pc,
                              input logic [31:0] exp_pc);
        refetch_ready = 1'b1;
        issue(3'b001, idx, pc);
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++; if (tlb_we !== 1'b1) begin miscompares++;
            $display("FAIL wr_we: got %b want 1", tlb_we); end
        vectors++; if (tlb_w_index !== idx) begin miscompares++;
            $display("FAIL wr_index: got %0d want %0d", tlb_w_index, idx); end
        vectors++; if ({cmd_ready, tlb_busy, refetch_valid} !== 3'b010) begin miscompares++;
            $display("FAIL wr_c1_ctl: got %b want 010", {cmd_ready, tlb_busy, refetch_valid}); end
        @(negedge clk);
        vectors++; if (refetch_valid !== 1'b1) begin miscompares++;
            $display("FAIL wr_refetch_valid: got %b want 1", refetch_valid); end
        vectors++; if (refetch_pc !== exp_pc) begin miscompares++;
            $display("FAIL wr_refetch_pc: got %h want %h", refetch_pc, exp_pc); end
        vectors++; if ({tlb_we, tlb_w_index} !== 5'b0) begin miscompares++;
            $display("FAIL wr_c2_we_clear: got %b want 0", {tlb_we, tlb_w_index}); end
        @(negedge clk);
        vectors++; if ({cmd_ready, tlb_busy, refetch_valid} !== 3'b100) begin miscompares++;
            $display("FAIL wr_c3_idle: got %b want 100", {cmd_ready, tlb_busy, refetch_valid}); end
    endtask

    task automatic test_read(input logic r_e);
        refetch_ready = 1'b1;
        tlb_r_e = r_e;
        issue(3'b100, 4'd3, 32'h1C00_0200);
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++; if (tlb_r_index !== 4'd3) begin miscompares++;
            $display("FAIL rd_c1_index: got %0d want 3", tlb_r_index); end
        vectors++; if ({csr_tlbrd_we, tlb_we, cmd_ready, tlb_busy} !== 4'b0001) begin
            miscompares++; $display("FAIL rd_c1_ctl: got %b want 0001",
                {csr_tlbrd_we, tlb_we, cmd_ready, tlb_busy}); end
        @(negedge clk);
        vectors++; if (tlb_r_index !== 4'd3) begin miscompares++;
            $display("FAIL rd_c2_index: got %0d want 3", tlb_r_index); end
        vectors++; if (csr_tlbrd_we !== 1'b1) begin miscompares++;
            $display("FAIL rd_csr_we: got %b want 1", csr_tlbrd_we); end
        vectors++; if (csr_tlbrd_valid !== r_e) begin miscompares++;
            $display("FAIL rd_csr_valid: got %b want %b", csr_tlbrd_valid, r_e); end
        vectors++; if (refetch_valid !== 1'b0) begin miscompares++;
            $display("FAIL rd_c2_refetch: got %b want 0", refetch_valid); end
        @(negedge clk);
        vectors++; if ({refetch_valid, refetch_pc} !== {1'b1, 32'h1C00_0204}) begin
            miscompares++; $display("FAIL rd_refetch: got %b/%h want 1/1c000204",
                refetch_valid, refetch_pc); end
        vectors++; if ({csr_tlbrd_we, csr_tlbrd_valid, tlb_r_index} !== 6'b0) begin
            miscompares++; $display("FAIL rd_c3_clear: got %b want 0",
                {csr_tlbrd_we, csr_tlbrd_valid, tlb_r_index}); end
        @(negedge clk);
        vectors++; if ({cmd_ready, refetch_valid} !== 2'b10) begin miscompares++;
            $display("FAIL rd_c4_idle: got %b want 10", {cmd_ready, refetch_valid}); end
        tlb_r_e = 1'b0;
    endtask

    task automatic test_fill();
        logic [3:0] idx1;
        logic [3:0] idx2;
        refetch_ready = 1'b1;
        issue(3'b010, 4'd9, 32'h1C00_0300);
        @(negedge clk);
        cmd_valid = 1'b0;
        idx1 = tlb_w_index;
        vectors++; if (tlb_we !== 1'b1) begin miscompares++;
            $display("FAIL fill1_we: got %b want 1", tlb_we); end
        vectors++; if (idx1 !== fill_at_edge) begin miscompares++;
            $display("FAIL fill1_index: got %0d want %0d", idx1, fill_at_edge); end
        @(negedge clk);
        vectors++; if ({refetch_valid, refetch_pc} !== {1'b1, 32'h1C00_0304}) begin
            miscompares++; $display("FAIL fill1_refetch: got %b/%h want 1/1c000304",
                refetch_valid, refetch_pc); end
        repeat (14) @(negedge clk);
        issue(3'b010, 4'd9, 32'h1C00_0400);
        @(negedge clk);
        cmd_valid = 1'b0;
        idx2 = tlb_w_index;
        vectors++; if (idx2 !== fill_at_edge) begin miscompares++;
            $display("FAIL fill2_index: got %0d want %0d", idx2, fill_at_edge); end
`ifdef TLB_FILL_LFSR_EN
        vectors++; if (idx1 === idx2) begin miscompares++;
            $display("FAIL fill_lfsr_differ: got %0d and %0d want different", idx1, idx2); end
        vectors++; if (idx1 === 4'd0 || idx2 === 4'd0) begin miscompares++;
            $display("FAIL fill_lfsr_nonzero: got %0d and %0d want nonzero", idx1, idx2); end
`else
        vectors++; if (idx1 !== idx2) begin miscompares++;
            $display("FAIL fill_cnt_same: got %0d and %0d want equal", idx1, idx2); end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        refetch_ready = 1'b0;
        issue(3'b001, 4'd7, 32'h2000_0000);
        @(negedge clk);
        vectors++; if ({tlb_we, tlb_w_index} !== {1'b1, 4'd7}) begin miscompares++;
            $display("FAIL stall_we: got %b/%0d want 1/7", tlb_we, tlb_w_index); end
        issue(3'b001, 4'd9, 32'h3000_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++; if ({refetch_valid, refetch_pc} !== {1'b1, 32'h2000_0004}) begin
                miscompares++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/20000004", i,
                    refetch_valid, refetch_pc); end
            vectors++; if ({cmd_ready, tlb_busy, tlb_we} !== 3'b010) begin miscompares++;
                $display("FAIL stall_ctl[%0d]: got %b want 010", i,
                    {cmd_ready, tlb_busy, tlb_we}); end
        end
        cmd_valid = 1'b0;
        refetch_ready = 1'b1;
        @(negedge clk);
        vectors++; if ({cmd_ready, tlb_busy, refetch_valid, tlb_we} !== 4'b1000) begin
            miscompares++; $display("FAIL stall_release: got %b want 1000",
                {cmd_ready, tlb_busy, refetch_valid, tlb_we}); end
    endtask

    task automatic test_bad_op();
        refetch_ready = 1'b1;
        issue(3'b011, 4'd4, 32'h1C00_0500);
        @(negedge clk);
        vectors++; if ({cmd_ready, tlb_busy, tlb_we, csr_tlbrd_we} !== 4'b1000) begin
            miscompares++; $display("FAIL bad011_ctl: got %b want 1000",
                {cmd_ready, tlb_busy, tlb_we, csr_tlbrd_we}); end
        issue(3'b000, 4'd4, 32'h1C00_0600);
        @(negedge clk);
        vectors++; if ({cmd_ready, tlb_busy, tlb_we, csr_tlbrd_we} !== 4'b1000) begin
            miscompares++; $display("FAIL bad000_ctl: got %b want 1000",
                {cmd_ready, tlb_busy, tlb_we, csr_tlbrd_we}); end
        cmd_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++; if ({refetch_valid, tlb_we, csr_tlbrd_we, tlb_busy} !== 4'b0) begin
                miscompares++; $display("FAIL bad_quiet[%0d]: got %b want 0000", i,
                    {refetch_valid, tlb_we, csr_tlbrd_we, tlb_busy}); end
        end
    endtask

    task automatic test_reset_mid_read();
        refetch_ready = 1'b1;
        tlb_r_e = 1'b1;
        issue(3'b100, 4'd6, 32'h1C00_0700);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        vectors++; if ({csr_tlbrd_we, tlb_r_index} !== {1'b1, 4'd6}) begin miscompares++;
            $display("FAIL rstmid_pre: got %b/%0d want 1/6", csr_tlbrd_we, tlb_r_index); end
        resetn = 1'b0;
        #1;
        vectors++; if ({csr_tlbrd_we, csr_tlbrd_valid, tlb_r_index, tlb_busy} !== 7'b0) begin
            miscompares++; $display("FAIL rstmid_clear: got %b want 0",
                {csr_tlbrd_we, csr_tlbrd_valid, tlb_r_index, tlb_busy}); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++;
            $display("FAIL rstmid_ready: got %b want 1", cmd_ready); end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++; if ({cmd_ready, refetch_valid, csr_tlbrd_we} !== 3'b100) begin
                miscompares++; $display("FAIL rstmid_after[%0d]: got %b want 100", i,
                    {cmd_ready, refetch_valid, csr_tlbrd_we}); end
        end
        tlb_r_e = 1'b0;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        resetn           = 1'b0;
        cmd_valid        = 1'b0;
        cmd_op           = 3'b000;
        cmd_pc           = 32'h0;
        csr_tlbidx_index = 4'd0;
        tlb_r_e          = 1'b0;
        refetch_ready    = 1'b0;

        test_reset();
        test_write(4'd5, 32'h1C00_0100, 32'h1C00_0104);
        test_read(1'b1);
        test_read(1'b0);
        test_fill();
        test_stall();
        test_bad_op();
        test_write(4'd15, 32'hFFFF_FFFC, 32'h0000_0000);
        test_reset_mid_read();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
